// File: rtl/updown_dir_ctrl.sv
// updown_dir_ctrl: debounced direction toggle with optional ping-pong reversal at count limits
module updown_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       auto_rev,
  input  logic [3:0] count_in,
  output logic       up_down,
  output logic       dir_pulse,
  output logic       btn_level
);
  localparam logic [1:0] IDLE = 2'd0, ARM_PRESS = 2'd1, HELD = 2'd2, ARM_REL = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1, btn_s, done, press, ud_n;
  logic [1:0] state, state_n;
  logic [CNT_W-1:0] dcnt;
  assign done = dcnt == LAST;
  assign press = state == ARM_PRESS && btn_s && done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = btn_s ? ARM_PRESS : IDLE;
      ARM_PRESS: state_n = !btn_s ? IDLE : done ? HELD : ARM_PRESS;
      HELD:      state_n = btn_s ? HELD : ARM_REL;
      default:   state_n = btn_s ? HELD : done ? IDLE : ARM_REL;
    endcase
  end
  // a confirmed press overrides the limit check in the same cycle
  assign ud_n = press ? ~up_down :
                (auto_rev && up_down && count_in == 4'hF) ? 1'b0 :
                (auto_rev && !up_down && count_in == 4'h0) ? 1'b1 : up_down;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      btn_s <= 1'b0;
      state <= IDLE;
      dcnt <= '0;
      up_down <= 1'b1;
      dir_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      s1 <= btn_raw;
      btn_s <= s1;
      state <= state_n;
      dcnt <= state_n != state ? '0 : (state == ARM_PRESS || state == ARM_REL) ? dcnt + 1'b1 : dcnt;
      up_down <= ud_n;
      dir_pulse <= ud_n != up_down;
      btn_level <= state_n == HELD || state_n == ARM_REL;
    end
  end
endmodule
